// File: rtl/control.sv
// control: SSD1306 OLED controller. Sends INIT after reset, then toggles inverse mode once per debounced button press.
// Latency: a press starts a frame 2 + DEBOUNCE + up to CLK_DIV clocks later when READY. One I2C bit is 4*CLK_DIV clocks.
// Backpressure: none. Presses made while a frame is in flight are held in a sticky flag, and several presses collapse into one.
// Ports:  clk (27 MHz), rst (async, active-high), bbutton (active-low, async to clk),
//         sck / sda (I2C SCL / SDA; a line is released by driving it to 1).
// Optional: define CONTROL_AUTO_BLINK_EN to also toggle every BLINK_PERIOD clocks once INIT has completed.
module control #(
  parameter int CLK_DIV      = 17,
  parameter int DEBOUNCE     = 64,
  parameter int BLINK_PERIOD = 27000000
) (
  input  logic clk,
  input  logic rst,
  input  logic bbutton,
  output logic sck,
  output logic sda
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {S_INIT, S_READY, S_TOGGLE} seq_t;
  typedef enum logic [2:0] {E_IDLE, E_START, E_DATA, E_ACK, E_STOP} eng_t;

  // Quarter-bit tick
  logic [QW-1:0] qcnt;
  logic          q_tick;

  assign q_tick = (qcnt == QW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         qcnt <= '0;
    else if (q_tick) qcnt <= '0;
    else             qcnt <= qcnt + 1'b1;
  end

  // Button conditioner: synchroniser, then a hold-time debouncer
  logic [1:0]    btn_sync;
  logic          btn_s;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic          db_hit;
  logic          press;

  assign btn_s  = btn_sync[1];
  assign db_hit = (btn_s != db_level) && (db_cnt == DW'(DEBOUNCE - 1));
  assign press  = db_hit && !btn_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync <= 2'b11;
      db_level <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_sync <= {btn_sync[0], bbutton};
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Sequencer and bit-engine state
  seq_t       seq, seq_n;
  eng_t       est, est_n;
  logic [1:0] phase, phase_n;
  logic [2:0] bitc, bitc_n;
  logic [2:0] byte_idx, idx_n;
  logic [7:0] shreg, sh_n;
  logic [1:0] gap, gap_n;
  logic       pending;
  logic       inv;
  logic       blink_tick;
  logic       frame_done;
  logic       tx_req;
  logic       take;
  logic       init_frame;
  logic [2:0] last_idx;
  logic       sck_d, sda_d;

  assign frame_done = q_tick && (est == E_STOP) && (phase == 2'd3);

  function automatic logic [7:0] cmd_byte(input logic is_init, input logic [2:0] idx,
                                          input logic inv_now);
    case (idx)
      3'd0:    cmd_byte = 8'h78;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = is_init ? 8'hAE : (inv_now ? 8'hA6 : 8'hA7);
      3'd3:    cmd_byte = 8'h8D;
      3'd4:    cmd_byte = 8'h14;
      default: cmd_byte = 8'hAF;
    endcase
  endfunction

  // A press that coincides with taking the flag is a fresh press, so set wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       pending <= 1'b0;
    else if (press || blink_tick)  pending <= 1'b1;
    else if (take)                 pending <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   inv <= 1'b0;
    else if ((seq == S_TOGGLE) && frame_done)  inv <= ~inv;
  end

`ifdef CONTROL_AUTO_BLINK_EN
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  logic [BW-1:0] blink_cnt;
  logic          init_done;

  assign blink_tick = init_done && (blink_cnt == BW'(BLINK_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      init_done <= 1'b0;
    end else begin
      if ((seq == S_INIT) && frame_done) init_done <= 1'b1;
      if (init_done) blink_cnt <= blink_tick ? '0 : blink_cnt + 1'b1;
    end
  end
`else
  // BLINK_PERIOD only matters in auto-blink builds.
  logic unused_blink_period;
  assign unused_blink_period = (BLINK_PERIOD > 0);
  assign blink_tick = 1'b0;
`endif

  // Sequencer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq <= S_INIT;
    else     seq <= seq_n;
  end

  always_comb begin
    seq_n = seq;
    case (seq)
      S_INIT:   if (frame_done) seq_n = S_READY;
      S_READY:  if (pending)    seq_n = S_TOGGLE;
      S_TOGGLE: if (frame_done) seq_n = S_READY;
      default:  seq_n = S_INIT;
    endcase
  end

  always_comb begin
    tx_req     = (seq == S_INIT) || (seq == S_TOGGLE);
    take       = (seq == S_READY) && pending;
    init_frame = (seq == S_INIT);
    last_idx   = init_frame ? 3'd5 : 3'd2;
  end

  // Bit engine FSM. It advances only on quarter ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est      <= E_IDLE;
      phase    <= 2'd0;
      bitc     <= 3'd0;
      byte_idx <= 3'd0;
      shreg    <= 8'hFF;
      gap      <= 2'd2;   // counts as an idle bus, so the first Q after reset can START
    end else begin
      est      <= est_n;
      phase    <= phase_n;
      bitc     <= bitc_n;
      byte_idx <= idx_n;
      shreg    <= sh_n;
      gap      <= gap_n;
    end
  end

  always_comb begin
    est_n   = est;
    phase_n = phase;
    bitc_n  = bitc;
    idx_n   = byte_idx;
    sh_n    = shreg;
    gap_n   = gap;
    if (q_tick) begin
      case (est)
        E_IDLE: begin
          if (tx_req && (gap == 2'd2)) begin
            est_n   = E_START;
            phase_n = 2'd0;
          end else if (gap != 2'd2) begin
            gap_n = gap + 2'd1;
          end
        end
        E_START: begin
          if (phase == 2'd0) begin
            phase_n = 2'd1;
          end else begin
            est_n   = E_DATA;
            phase_n = 2'd0;
            bitc_n  = 3'd0;
            idx_n   = 3'd0;
            sh_n    = cmd_byte(init_frame, 3'd0, inv);
          end
        end
        E_DATA: begin
          if (phase != 2'd3) begin
            phase_n = phase + 2'd1;
          end else begin
            phase_n = 2'd0;
            if (bitc == 3'd7) begin
              est_n = E_ACK;
            end else begin
              bitc_n = bitc + 3'd1;
              sh_n   = {shreg[6:0], 1'b0};
            end
          end
        end
        E_ACK: begin
          if (phase != 2'd3) begin
            phase_n = phase + 2'd1;
          end else begin
            phase_n = 2'd0;
            if (byte_idx == last_idx) begin
              est_n = E_STOP;
            end else begin
              est_n  = E_DATA;
              bitc_n = 3'd0;
              idx_n  = byte_idx + 3'd1;
              sh_n   = cmd_byte(init_frame, byte_idx + 3'd1, inv);
            end
          end
        end
        E_STOP: begin
          if (phase != 2'd3) begin
            phase_n = phase + 2'd1;
          end else begin
            est_n   = E_IDLE;
            phase_n = 2'd0;
            gap_n   = 2'd0;
          end
        end
        default: est_n = E_IDLE;
      endcase
    end
  end

  // Line levels per engine state. STOP holds SCL low for two Q so SCL low time is never shorter than a data bit's.
  always_comb begin
    sck_d = 1'b1;
    sda_d = 1'b1;
    case (est)
      E_START: begin
        sck_d = (phase == 2'd0);
        sda_d = 1'b0;
      end
      E_DATA: begin
        sck_d = phase[1];
        sda_d = shreg[7];
      end
      E_ACK: begin
        sck_d = phase[1];
        sda_d = 1'b1;
      end
      E_STOP: begin
        sck_d = phase[1];
        sda_d = (phase == 2'd3);
      end
      default: begin
        sck_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  // Registered pins: no decode glitches on SCL, and reset releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck <= 1'b1;
      sda <= 1'b1;
    end else begin
      sck <= sck_d;
      sda <= sda_d;
    end
  end

endmodule

// File: tb/tb_control.sv
// tb_control: directed and random button stimulus for control. An I2C bus decoder and a protocol checker watch sck/sda.
// Decoded frames are compared against a frame list built from the command rules:
// INIT after every reset, then one toggle frame per accepted press, alternating A7/A6.
module tb_control;
  localparam int CLK_DIV  = 17;
  localparam int DEBOUNCE = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bbutton = 1'b1;
  logic sck, sda;

  control #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .BLINK_PERIOD(27000000)) dut (
    .clk(clk), .rst(rst), .bbutton(bbutton), .sck(sck), .sda(sda)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          len;
    logic [47:0] dat;
  } frame_t;

  frame_t got_q[$];
  frame_t exp_q[$];
  bit     inv_m = 1'b0;

  localparam logic [47:0] INIT_DAT = 48'h7800_AE8D_14AF;

  task automatic exp_init();
    exp_q.push_back('{len: 6, dat: INIT_DAT});
    inv_m = 1'b0;
  endtask

  task automatic exp_toggle();
    exp_q.push_back('{len: 3, dat: (inv_m ? 48'h7800A6 : 48'h7800A7)});
    inv_m = ~inv_m;
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_len"}, got_q[i].len, exp_q[i].len);
      chk({tag, "_dat"}, got_q[i].dat, exp_q[i].dat);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Bus decoder and protocol checker, sampling between active edges
  logic        p_sck = 1'b1, p_sda = 1'b1;
  logic        in_frame = 1'b0;
  logic        hb = 1'b0, bv = 1'b0;
  int          bitn = 0;
  int          run = 0;
  int          flen = 0;
  logic [7:0]  sh = '0;
  logic [47:0] fdat = '0;

  always @(negedge clk) begin
    if (rst) begin
      p_sck = 1'b1; p_sda = 1'b1; in_frame = 1'b0; hb = 1'b0; bitn = 0; run = 0;
    end else begin
      if (sck !== p_sck) begin
        chk("scl_width", (run >= 2 * CLK_DIV), 1'b1);
        run = 1;
      end else begin
        run++;
      end
      if (p_sck && sck && (sda !== p_sda)) begin
        if (!sda) begin
          chk("start_when_idle", in_frame, 1'b0);
          in_frame = 1'b1; bitn = 0; flen = 0; fdat = '0; hb = 1'b0;
        end else begin
          chk("stop_in_frame", in_frame, 1'b1);
          chk("stop_byte_aligned", bitn, 0);
          if (in_frame) got_q.push_back('{len: flen, dat: fdat});
          in_frame = 1'b0; hb = 1'b0;
        end
      end else if (!p_sck && sck) begin
        chk("scl_rise_in_frame", in_frame, 1'b1);
        hb = 1'b1; bv = sda;
      end else if (p_sck && !sck && in_frame && hb) begin
        hb = 1'b0;
        bitn++;
        if (bitn <= 8) begin
          sh = {sh[6:0], bv};
        end else begin
          chk("ack_released", bv, 1'b1);
          fdat = {fdat[39:0], sh};
          flen++;
          bitn = 0;
        end
      end
      p_sck = sck; p_sda = sda;
    end
  end

  task automatic press(input int w);
    bbutton = 1'b0;
    repeat (w) @(negedge clk);
    bbutton = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w;
    int k;
    bit long_p;

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 1'b1);
    chk("rst_sda", sda, 1'b1);
    rst = 1'b0;

    // Idle after reset: exactly one INIT frame, then the bus is released
    exp_init();
    repeat (5000) @(negedge clk);
    cmp_frames("idle_init");
    chk("idle_sck", sck, 1'b1);
    chk("idle_sda", sda, 1'b1);

    // Press during INIT is latched and serviced after INIT
    do_reset();
    exp_init();
    repeat (1000) @(negedge clk);
    press(250);
    exp_toggle();
    repeat (6000) @(negedge clk);
    cmp_frames("press_in_init");

    // Two separate presses give two frames with alternating inverse command
    press(300); exp_toggle();
    repeat (2500) @(negedge clk);
    press(300); exp_toggle();
    repeat (2500) @(negedge clk);
    cmp_frames("two_press");

    // Glitch shorter than the debounce window is ignored
    press(10);
    repeat (2500) @(negedge clk);
    cmp_frames("glitch");

    // Presses made while a toggle frame is in flight collapse into one further frame
    press(300); exp_toggle();
    repeat (100) @(negedge clk);
    press(100);
    repeat (100) @(negedge clk);
    press(100); exp_toggle();
    repeat (4000) @(negedge clk);
    cmp_frames("collapse");

    // Random press widths well clear of the debounce threshold
    for (int i = 0; i < 8; i++) begin
      long_p = 1'($urandom_range(0, 1));
      w = long_p ? int'($urandom_range(DEBOUNCE + 8, DEBOUNCE + 300))
                 : int'($urandom_range(1, DEBOUNCE - 8));
      press(w);
      if (long_p) exp_toggle();
      repeat (2400) @(negedge clk);
    end
    cmp_frames("random");

    // Reset in the middle of INIT: lines release asynchronously, INIT restarts, inv is cleared
    do_reset();
    repeat ($urandom_range(300, 3000)) @(negedge clk);
    k = 0;
    while (k < 200 && sck !== 1'b0) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_scl_low", sck, 1'b0);
    chk("pre_rst_in_frame", in_frame, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sck", sck, 1'b1);
    chk("async_rst_sda", sda, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_init();
    repeat (4500) @(negedge clk);
    press(300); exp_toggle();
    repeat (2500) @(negedge clk);
    cmp_frames("rst_mid_init");
    chk("end_sck", sck, 1'b1);
    chk("end_sda", sda, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
